// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default parameter
// values, width helpers and the parameter legality check.
package fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  // Pointer width; at least one bit even for the smallest legal depth.
  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must be able to represent the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Legal parameter set: width >= 1, depth >= 2, AF in 1..DEPTH, AE in 0..DEPTH-1.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_level, input int ae_level);
    return (data_w >= 1) && (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO. The FIFO takes the slave
// side; whoever writes and reads it takes the master side.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  fill_count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, data_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_dpram.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered
// read port. The read register is the FIFO's data_out and holds its value
// whenever no read is requested. Storage itself is never cleared.
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: a same-edge write to the read address is not seen, so a
  // simultaneous write/read on a full FIFO returns the old word.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, registered
// status flags and error pulses. Storage lives in fifo_dpram.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  C_AE    = CNT_W'(AE_LEVEL);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(DEPTH - 1);

  if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_err
    $error("fifo_sync_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ov;
  logic              r_un;
  logic              r_dv;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_rdata;

  // Explicit wrap so a non-power-of-two depth works.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == A_LAST) ? '0 : p + 1'b1;
  endfunction

  // Occupancy update: simultaneous write and read leave the count unchanged.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  // A full FIFO still takes a write when a read frees a slot on the same edge;
  // an empty FIFO never forwards the incoming word to the reader.
  assign w_rd_acc    = bus.rd & ~r_empty;
  assign w_wr_acc    = bus.wr & (~r_full | bus.rd);
  assign w_count_nxt = count_next(r_count, w_wr_acc, w_rd_acc);

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc & ~rst),
    .i_waddr (r_wptr),
    .i_wdata (bus.data_in),
    .i_re    (w_rd_acc & ~rst),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Pointer, count and flag registers; flags come from the post-update count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= ptr_next(r_wptr);
      if (w_rd_acc) r_rptr <= ptr_next(r_rptr);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      r_ov    <= bus.wr & ~w_wr_acc;
      r_un    <= bus.rd & ~w_rd_acc;
      r_dv    <= w_rd_acc;
    end
  end

  assign bus.data_out     = w_rdata;
  assign bus.data_valid   = r_dv;
  assign bus.fifo_full    = r_full;
  assign bus.fifo_empty   = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.fill_count   = r_count;
  assign bus.overflow     = r_ov;
  assign bus.underflow    = r_un;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a DEPTH=16 and a DEPTH=5 instance run side by
// side, each shadowed every cycle by a queue-based reference model.
module tb_fifo_sync_param;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef logic [7:0] q_t [$];

  typedef struct packed {
    logic [7:0] dout;
    logic       dv;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic [4:0] cnt;
    logic       ov;
    logic       un;
  } obs_t;

  typedef struct {
    logic       r, w, rd;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       full, empty, af, ae;
    logic [7:0] dout;
    logic       dv, ov, un;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  q_t   q16, q5;
  obs_t e16, e5;
  vec_t tbl[18];

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(8), .DEPTH(16)) b16 ();
  fifo_sync_param_if #(.DATA_W(8), .DEPTH(5))  b5  ();

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u16 (
    .clk(clk), .rst(rst), .bus(b16));
  fifo_sync_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u5 (
    .clk(clk), .rst(rst), .bus(b5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: a FIFO is a queue; flags are plain predicates on its size.
  task automatic model_step(ref q_t q, inout obs_t e, input int depth, input int af,
                            input int ae, input logic r, input logic w,
                            input logic rd, input logic [7:0] d);
    bit rd_ok, wr_ok;
    if (r) begin
      q.delete();
      e.dout = 8'h00; e.dv = 1'b0; e.ov = 1'b0; e.un = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = w && ((q.size() < depth) || rd);
      e.dv = rd_ok;
      if (rd_ok) e.dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      e.ov = w && !wr_ok;
      e.un = rd && !rd_ok;
    end
    e.cnt   = 5'(q.size());
    e.full  = (q.size() == depth);
    e.empty = (q.size() == 0);
    e.af    = (q.size() >= af);
    e.ae    = (q.size() <= ae);
  endtask

  function automatic obs_t obs16();
    obs_t a;
    a.dout = b16.data_out;    a.dv = b16.data_valid;
    a.full = b16.fifo_full;   a.empty = b16.fifo_empty;
    a.af   = b16.almost_full; a.ae = b16.almost_empty;
    a.cnt  = b16.fill_count;  a.ov = b16.overflow; a.un = b16.underflow;
    return a;
  endfunction

  function automatic obs_t obs5();
    obs_t a;
    a.dout = b5.data_out;    a.dv = b5.data_valid;
    a.full = b5.fifo_full;   a.empty = b5.fifo_empty;
    a.af   = b5.almost_full; a.ae = b5.almost_empty;
    a.cnt  = 5'(b5.fill_count); a.ov = b5.overflow; a.un = b5.underflow;
    return a;
  endfunction

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk($sformatf("%s c%0d data_out", tag, cyc),     32'(a.dout),  32'(e.dout));
    chk($sformatf("%s c%0d data_valid", tag, cyc),   32'(a.dv),    32'(e.dv));
    chk($sformatf("%s c%0d fifo_full", tag, cyc),    32'(a.full),  32'(e.full));
    chk($sformatf("%s c%0d fifo_empty", tag, cyc),   32'(a.empty), 32'(e.empty));
    chk($sformatf("%s c%0d almost_full", tag, cyc),  32'(a.af),    32'(e.af));
    chk($sformatf("%s c%0d almost_empty", tag, cyc), 32'(a.ae),    32'(e.ae));
    chk($sformatf("%s c%0d fill_count", tag, cyc),   32'(a.cnt),   32'(e.cnt));
    chk($sformatf("%s c%0d overflow", tag, cyc),     32'(a.ov),    32'(e.ov));
    chk($sformatf("%s c%0d underflow", tag, cyc),    32'(a.un),    32'(e.un));
  endtask

  // One clock: drive the selected instance, idle the other, check both.
  task automatic step(input int which, input logic r, input logic w,
                      input logic rd, input logic [7:0] d);
    logic w16, r16, w5, r5;
    w16 = (which == 16) ? w  : 1'b0;
    r16 = (which == 16) ? rd : 1'b0;
    w5  = (which == 5)  ? w  : 1'b0;
    r5  = (which == 5)  ? rd : 1'b0;
    rst = r;
    b16.wr = w16; b16.rd = r16; b16.data_in = d;
    b5.wr  = w5;  b5.rd  = r5;  b5.data_in  = d;
    model_step(q16, e16, 16, 14, 2, r, w16, r16, d);
    model_step(q5,  e5,  5,  4,  1, r, w5,  r5,  d);
    @(posedge clk);
    #1;
    cyc++;
    cmp("D16", obs16(), e16);
    cmp("D5",  obs5(),  e5);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic rd,
                              input logic [7:0] d, input logic [4:0] cnt,
                              input logic full, input logic empty, input logic af,
                              input logic ae, input logic [7:0] dout,
                              input logic dv, input logic ov, input logic un);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.d = d; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.dout = dout; v.dv = dv; v.ov = ov; v.un = un;
    return v;
  endfunction

  initial begin
    // DEPTH=5, AF=4, AE=1: fill to full, overflow, full write+read, drain,
    // underflow, empty write+read (no bypass), pointer wrap.
    tbl[0]  = mk(H,L,L,8'h00, 5'd0, L,H,L,H, 8'h00, L,L,L);
    tbl[1]  = mk(L,L,H,8'h00, 5'd0, L,H,L,H, 8'h00, L,L,H);
    tbl[2]  = mk(L,H,L,8'h11, 5'd1, L,L,L,H, 8'h00, L,L,L);
    tbl[3]  = mk(L,H,L,8'h22, 5'd2, L,L,L,L, 8'h00, L,L,L);
    tbl[4]  = mk(L,H,L,8'h33, 5'd3, L,L,L,L, 8'h00, L,L,L);
    tbl[5]  = mk(L,H,L,8'h44, 5'd4, L,L,H,L, 8'h00, L,L,L);
    tbl[6]  = mk(L,H,L,8'h55, 5'd5, H,L,H,L, 8'h00, L,L,L);
    tbl[7]  = mk(L,H,L,8'h66, 5'd5, H,L,H,L, 8'h00, L,H,L);
    tbl[8]  = mk(L,H,H,8'h77, 5'd5, H,L,H,L, 8'h11, H,L,L);
    tbl[9]  = mk(L,L,H,8'h00, 5'd4, L,L,H,L, 8'h22, H,L,L);
    tbl[10] = mk(L,L,H,8'h00, 5'd3, L,L,L,L, 8'h33, H,L,L);
    tbl[11] = mk(L,L,H,8'h00, 5'd2, L,L,L,L, 8'h44, H,L,L);
    tbl[12] = mk(L,L,H,8'h00, 5'd1, L,L,L,H, 8'h55, H,L,L);
    tbl[13] = mk(L,L,H,8'h00, 5'd0, L,H,L,H, 8'h77, H,L,L);
    tbl[14] = mk(L,H,H,8'h88, 5'd1, L,L,L,H, 8'h77, L,L,H);
    tbl[15] = mk(L,L,L,8'h00, 5'd1, L,L,L,H, 8'h77, L,L,L);
    tbl[16] = mk(L,L,H,8'h00, 5'd0, L,H,L,H, 8'h88, H,L,L);
    tbl[17] = mk(L,L,L,8'h00, 5'd0, L,H,L,H, 8'h88, L,L,L);

    // Reset, then idle.
    step(16, H, L, L, 8'h00);
    step(16, L, L, L, 8'h00);
    chk("idle empty",     32'(b16.fifo_empty),   32'd1);
    chk("idle almost_e",  32'(b16.almost_empty), 32'd1);
    chk("idle count",     32'(b16.fill_count),   32'd0);
    chk("idle valid",     32'(b16.data_valid),   32'd0);
    chk("idle overflow",  32'(b16.overflow),     32'd0);
    chk("idle underflow", 32'(b16.underflow),    32'd0);

    // Fill 0x01..0x10, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      step(16, L, H, L, 8'(i));
      chk($sformatf("fill%0d almost_full", i), 32'(b16.almost_full), 32'(i >= 14));
      chk($sformatf("fill%0d fill_count", i),  32'(b16.fill_count),  32'(i));
    end
    chk("full flag", 32'(b16.fifo_full), 32'd1);
    step(16, L, H, L, 8'hFF);
    chk("overflow pulse",  32'(b16.overflow),   32'd1);
    chk("overflow count",  32'(b16.fill_count), 32'd16);
    step(16, L, L, L, 8'h00);
    chk("overflow cleared", 32'(b16.overflow),  32'd0);

    // Drain in order, then read from empty.
    for (int i = 1; i <= 16; i++) begin
      step(16, L, L, H, 8'h00);
      chk($sformatf("drain%0d data", i),  32'(b16.data_out),   32'(i));
      chk($sformatf("drain%0d valid", i), 32'(b16.data_valid), 32'd1);
    end
    chk("drained empty", 32'(b16.fifo_empty), 32'd1);
    step(16, L, L, H, 8'h00);
    chk("underflow pulse", 32'(b16.underflow), 32'd1);
    chk("underflow hold",  32'(b16.data_out),  32'h10);

    // Full write+read returns the oldest word; new word comes out last.
    for (int i = 1; i <= 16; i++) step(16, L, H, L, 8'(i));
    step(16, L, H, H, 8'hAA);
    chk("full wr+rd data",  32'(b16.data_out),   32'h01);
    chk("full wr+rd count", 32'(b16.fill_count), 32'd16);
    for (int i = 2; i <= 17; i++) begin
      step(16, L, L, H, 8'h00);
      chk($sformatf("redrain%0d data", i), 32'(b16.data_out), (i == 17) ? 32'hAA : 32'(i));
    end

    // Reset with 7 entries while writing and reading.
    for (int i = 0; i < 7; i++) step(16, L, H, L, 8'(8'h20 + i));
    step(16, H, H, H, 8'h77);
    chk("rst count", 32'(b16.fill_count), 32'd0);
    chk("rst empty", 32'(b16.fifo_empty), 32'd1);
    chk("rst valid", 32'(b16.data_valid), 32'd0);
    step(16, L, H, L, 8'h5A);
    step(16, L, L, H, 8'h00);
    chk("post-rst data",  32'(b16.data_out),   32'h5A);
    chk("post-rst valid", 32'(b16.data_valid), 32'd1);

    // Table vectors on the DEPTH=5 instance.
    for (int i = 0; i < 18; i++) begin
      step(5, tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d fill_count", i),   32'(b5.fill_count),   32'(tbl[i].cnt));
      chk($sformatf("tbl%0d fifo_full", i),    32'(b5.fifo_full),    32'(tbl[i].full));
      chk($sformatf("tbl%0d fifo_empty", i),   32'(b5.fifo_empty),   32'(tbl[i].empty));
      chk($sformatf("tbl%0d almost_full", i),  32'(b5.almost_full),  32'(tbl[i].af));
      chk($sformatf("tbl%0d almost_empty", i), 32'(b5.almost_empty), 32'(tbl[i].ae));
      chk($sformatf("tbl%0d data_out", i),     32'(b5.data_out),     32'(tbl[i].dout));
      chk($sformatf("tbl%0d data_valid", i),   32'(b5.data_valid),   32'(tbl[i].dv));
      chk($sformatf("tbl%0d overflow", i),     32'(b5.overflow),     32'(tbl[i].ov));
      chk($sformatf("tbl%0d underflow", i),    32'(b5.underflow),    32'(tbl[i].un));
    end

    // DEPTH=5 wrap: three rounds of five writes then five reads.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) step(5, L, H, L, 8'(8'h40 + 5*k + j));
      for (int j = 0; j < 5; j++) begin
        step(5, L, L, H, 8'h00);
        chk($sformatf("wrap%0d.%0d data", k, j), 32'(b5.data_out), 32'(8'h40 + 5*k + j));
      end
    end

    // Randomised traffic, alternating write-heavy and read-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      for (int n = 0; n < 200; n++) begin
        int   pw;
        logic rr, ww, rdd;
        pw  = (ph % 2 == 0) ? 75 : 30;
        rr  = ($urandom_range(0, 99) == 0);
        ww  = ($urandom_range(0, 99) < pw);
        rdd = ($urandom_range(0, 99) < 100 - pw);
        step(($urandom_range(0, 1) == 0) ? 16 : 5, rr, ww, rdd, 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
